// File: rtl/rgb_to_colour_if.sv
// Stream bundle for rgb_to_colour: pixel-in handshake and colour-code-out handshake.
// The slave modport is the encoder's view; master is the source/sink side.
interface rgb_to_colour_if;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] rgb;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  colour;
    logic        exact;

    modport master (
        output in_valid, rgb, out_ready,
        input  in_ready, out_valid, colour, exact
    );

    modport slave (
        input  in_valid, rgb, out_ready,
        output in_ready, out_valid, colour, exact
    );
endinterface

// File: rtl/rgb_to_colour.sv
// Two-stage valid/ready encoder from 24-bit RGB to the 3-bit palette code, with an
// inexact-pixel counter. Define RGB_HIST_EN to build the per-colour histogram bins.
module rgb_to_colour #(
    parameter int unsigned THRESH = 128,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             cnt_clr,
    input  logic [2:0]       hist_sel,
    output logic [CNT_W-1:0] inexact_cnt,
    output logic [CNT_W-1:0] hist_data,
    rgb_to_colour_if.slave   bus
);

    localparam logic [7:0]       THR     = 8'(THRESH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    function automatic logic [2:0] quantise(input logic [23:0] px);
        return {px[23:16] >= THR, px[15:8] >= THR, px[7:0] >= THR};
    endfunction

    function automatic logic byte_exact(input logic [7:0] v);
        return (v == 8'h00) || (v == 8'hFF);
    endfunction

    function automatic logic is_exact(input logic [23:0] px);
        return byte_exact(px[23:16]) & byte_exact(px[15:8]) & byte_exact(px[7:0]);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    logic             s1_valid_q, s1_valid_d;
    logic [2:0]       s1_colour_q, s1_colour_d;
    logic             s1_exact_q, s1_exact_d;
    logic             out_valid_q, out_valid_d;
    logic [2:0]       colour_q, colour_d;
    logic             exact_q, exact_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic in_ready;
    logic in_fire;
    logic out_fire;
    logic s1_move;

    // in_ready looks through the output register so a full pipe still streams.
    assign out_fire = out_valid_q & bus.out_ready;
    assign s1_move  = enable & s1_valid_q & (~out_valid_q | bus.out_ready);
    assign in_ready = enable & (~s1_valid_q | s1_move);
    assign in_fire  = bus.in_valid & in_ready;

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_colour_d = s1_colour_q;
        s1_exact_d  = s1_exact_q;
        out_valid_d = out_valid_q;
        colour_d    = colour_q;
        exact_d     = exact_q;
        cnt_d       = cnt_q;

        if (s1_move) begin
            s1_valid_d = 1'b0;
        end
        if (in_fire) begin
            s1_valid_d  = 1'b1;
            s1_colour_d = quantise(bus.rgb);
            s1_exact_d  = is_exact(bus.rgb);
        end

        if (s1_move) begin
            out_valid_d = 1'b1;
            colour_d    = s1_colour_q;
            exact_d     = s1_exact_q;
        end else if (out_fire) begin
            out_valid_d = 1'b0;
        end

        if (cnt_clr) begin
            cnt_d = '0;
        end else if (out_fire && !exact_q) begin
            cnt_d = sat_inc(cnt_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_colour_q <= '0;
            s1_exact_q  <= 1'b0;
            out_valid_q <= 1'b0;
            colour_q    <= '0;
            exact_q     <= 1'b0;
            cnt_q       <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_colour_q <= s1_colour_d;
            s1_exact_q  <= s1_exact_d;
            out_valid_q <= out_valid_d;
            colour_q    <= colour_d;
            exact_q     <= exact_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.colour    = colour_q;
    assign bus.exact     = exact_q;
    assign inexact_cnt   = cnt_q;

`ifdef RGB_HIST_EN
    logic [CNT_W-1:0] bin_q [8];
    logic [CNT_W-1:0] bin_d [8];
    logic [CNT_W-1:0] hist_q;

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            bin_d[i] = bin_q[i];
            if (cnt_clr) begin
                bin_d[i] = '0;
            end else if (out_fire && (colour_q == 3'(i))) begin
                bin_d[i] = sat_inc(bin_q[i]);
            end
        end
    end

    // Read port samples the bins before this edge's update: one cycle of latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                bin_q[i] <= '0;
            end
            hist_q <= '0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                bin_q[i] <= bin_d[i];
            end
            hist_q <= bin_q[hist_sel];
        end
    end

    assign hist_data = hist_q;
`else
    logic unused_hist_sel;
    assign unused_hist_sel = ^hist_sel;
    assign hist_data       = '0;
`endif

endmodule

// File: tb/tb_rgb_to_colour.sv
// Bench for rgb_to_colour (CNT_W=4): vector table, directed stall/freeze/reset/counter
// sequences and a randomized run against a queue-based reference model.
`timescale 1ns/1ps
module tb_rgb_to_colour;
    localparam int CNT_W = 4;
    localparam int CMAX  = 15;

    typedef struct {
        logic [2:0] c;
        logic       e;
    } exp_t;

    typedef struct {
        logic [23:0] rgb;
        logic [2:0]  c;
        logic        e;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             enable;
    logic             cnt_clr;
    logic [2:0]       hist_sel;
    logic [CNT_W-1:0] inexact_cnt;
    logic [CNT_W-1:0] hist_data;

    rgb_to_colour_if bus();

    rgb_to_colour #(.THRESH(128), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .cnt_clr    (cnt_clr),
        .hist_sel   (hist_sel),
        .inexact_cnt(inexact_cnt),
        .hist_data  (hist_data),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int   ntests = 0;
    int   nfail  = 0;
    exp_t q[$];
    int   m_cnt = 0;
    int   m_bin[8];
    bit   last_inf;
    int   delivered = 0;

    // Reference: each channel compared numerically, exact means every channel is 0 or 255.
    function automatic exp_t model(input logic [23:0] p);
        exp_t r;
        int   ch;
        r.c = 3'd0;
        r.e = 1'b1;
        for (int k = 0; k < 3; k++) begin
            ch = int'((p >> (8 * (2 - k))) & 24'hFF);
            r.c[2-k] = (ch >= 128);
            if (ch != 0 && ch != 255) r.e = 1'b0;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_cnt = 0;
        for (int i = 0; i < 8; i++) m_bin[i] = 0;
    endtask

    // One clock: observe handshakes, advance the model, then compare after the edge.
    task automatic step();
        exp_t h;
        bit   outf;
        int   exp_hist;
        #1;
        last_inf = bus.in_valid & bus.in_ready;
        outf     = bus.out_valid & bus.out_ready;
        exp_hist = m_bin[hist_sel];
        check("ready_needs_enable", 32'(bus.in_ready & ~enable), 32'd0);
        if (bus.out_valid) check("out_has_data", 32'(q.size() > 0), 32'd1);
        if (outf && q.size() > 0) begin
            h = q.pop_front();
            check("out_colour", 32'(bus.colour), 32'(h.c));
            check("out_exact", 32'(bus.exact), 32'(h.e));
            delivered++;
            if (!cnt_clr && !h.e && m_cnt < CMAX) m_cnt++;
            if (!cnt_clr && m_bin[h.c] < CMAX) m_bin[h.c]++;
        end
        if (cnt_clr) begin
            m_cnt = 0;
            for (int i = 0; i < 8; i++) m_bin[i] = 0;
        end
        if (last_inf) q.push_back(model(bus.rgb));
        @(posedge clk);
        @(negedge clk);
        check("occupancy", 32'(q.size() <= 2), 32'd1);
        check("inexact_cnt", 32'(inexact_cnt), 32'(m_cnt));
`ifdef RGB_HIST_EN
        check("hist_data", 32'(hist_data), 32'(exp_hist));
`else
        check("hist_data", 32'(hist_data), 32'd0);
`endif
    endtask

    function automatic logic [7:0] rand_chan();
        case ($urandom_range(0, 4))
            0:       return 8'h00;
            1:       return 8'hFF;
            2:       return 8'h7F;
            3:       return 8'h80;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        tbl[13];
        logic [23:0] p[8];
        int          idx;
        int          d0;
        logic [2:0]  snap_c;
        logic        snap_e;

        for (int i = 0; i < 8; i++) begin
            tbl[i].rgb = {{8{i[2]}}, {8{i[1]}}, {8{i[0]}}};
            tbl[i].c   = 3'(i);
            tbl[i].e   = 1'b1;
        end
        tbl[8]  = '{24'h7F8000, 3'd2, 1'b0};
        tbl[9]  = '{24'h80807F, 3'd6, 1'b0};
        tbl[10] = '{24'h808080, 3'd7, 1'b0};
        tbl[11] = '{24'h00FF7F, 3'd2, 1'b0};
        tbl[12] = '{24'hFE0001, 3'd4, 1'b0};

        rst = 1'b1; enable = 1'b1; cnt_clr = 1'b0; hist_sel = 3'd0;
        bus.in_valid = 1'b0; bus.rgb = '0; bus.out_ready = 1'b1;
        model_reset();
        @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_colour", 32'(bus.colour), 32'd0);
        check("rst_exact", 32'(bus.exact), 32'd0);
        check("rst_cnt", 32'(inexact_cnt), 32'd0);
        check("rst_hist", 32'(hist_data), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;

        // Table: back-to-back stream, result for vector i-1 visible after vector i's edge.
        for (int i = 0; i <= 13; i++) begin
            bus.in_valid = (i < 13);
            bus.rgb      = (i < 13) ? tbl[i].rgb : 24'h0;
            step();
            if (i < 13) check("tbl_accept", 32'(last_inf), 32'd1);
            if (i >= 1) begin
                check("tbl_valid", 32'(bus.out_valid), 32'd1);
                check("tbl_colour", 32'(bus.colour), 32'(tbl[i-1].c));
                check("tbl_exact", 32'(bus.exact), 32'(tbl[i-1].e));
            end
            if (i == 9)  check("palette_cnt", 32'(inexact_cnt), 32'd0);
            if (i == 11) check("thresh_cnt", 32'(inexact_cnt), 32'd2);
        end
        bus.in_valid = 1'b0;
        repeat (3) step();

        // Backpressure: four offered, two held, then drained in order.
        p[0] = 24'h00FF00; p[1] = 24'hFF0000; p[2] = 24'h0000FF; p[3] = 24'hFFFF00;
        bus.out_ready = 1'b0;
        idx = 0;
        for (int n = 0; n < 4; n++) begin
            bus.in_valid = (idx < 4);
            bus.rgb      = p[idx & 3];
            step();
            if (last_inf) idx++;
        end
        check("bp_accepted", 32'(idx), 32'd2);
        check("bp_in_ready", 32'(bus.in_ready), 32'd0);
        check("bp_out_valid", 32'(bus.out_valid), 32'd1);
        check("bp_colour_hold", 32'(bus.colour), 32'd2);
        bus.out_ready = 1'b1;
        d0 = delivered;
        for (int n = 0; n < 20 && (idx < 4 || q.size() > 0); n++) begin
            bus.in_valid = (idx < 4);
            bus.rgb      = p[idx & 3];
            step();
            if (last_inf) idx++;
        end
        check("bp_delivered", 32'(delivered - d0), 32'd4);

        // Enable freeze mid-stream.
        for (int i = 0; i < 8; i++) p[i] = {rand_chan(), rand_chan(), rand_chan()};
        bus.in_valid = 1'b0;
        step();
        idx = 0;
        d0  = delivered;
        for (int n = 0; n < 3; n++) begin
            bus.in_valid = 1'b1;
            bus.rgb      = p[idx];
            step();
            if (last_inf) idx++;
        end
        snap_c = bus.colour;
        snap_e = bus.exact;
        enable = 1'b0;
        bus.out_ready = 1'b0;
        for (int n = 0; n < 5; n++) begin
            bus.rgb = p[idx];
            step();
            check("frz_in_ready", 32'(bus.in_ready), 32'd0);
            check("frz_out_valid", 32'(bus.out_valid), 32'd1);
            check("frz_colour", 32'(bus.colour), 32'(snap_c));
            check("frz_exact", 32'(bus.exact), 32'(snap_e));
        end
        bus.out_ready = 1'b1;
        step();
        check("frz_out_fire", 32'(bus.out_valid), 32'd0);
        enable = 1'b1;
        for (int n = 0; n < 30 && (idx < 8 || q.size() > 0); n++) begin
            bus.in_valid = (idx < 8);
            bus.rgb      = p[idx & 7];
            step();
            if (last_inf) idx++;
        end
        check("frz_delivered", 32'(delivered - d0), 32'd8);

        // Reset with two pixels in flight.
        bus.in_valid = 1'b1; bus.rgb = 24'h808080;
        step();
        bus.in_valid = 1'b0;
        repeat (2) step();
        check("pre_rst_cnt_nonzero", 32'(inexact_cnt != 0), 32'd1);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.rgb = 24'h7F7F7F; step();
        bus.rgb = 24'h123456; step();
        bus.in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_cnt", 32'(inexact_cnt), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1; bus.rgb = 24'hFF00FF; hist_sel = 3'd5;
        step();
        bus.in_valid = 1'b0;
        step();
        check("post_rst_valid", 32'(bus.out_valid), 32'd1);
        check("post_rst_colour", 32'(bus.colour), 32'd5);
        check("post_rst_exact", 32'(bus.exact), 32'd1);
        step();
        step();
`ifdef RGB_HIST_EN
        check("hist_bin5", 32'(hist_data), 32'd1);
`endif

        // Counter saturation and clear-wins.
        cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
        bus.in_valid = 1'b1; bus.rgb = 24'h808080;
        repeat (17) step();
        bus.in_valid = 1'b0;
        repeat (3) step();
        check("cnt_saturate", 32'(inexact_cnt), 32'd15);
        bus.in_valid = 1'b1; bus.rgb = 24'h010203;
        step();
        bus.in_valid = 1'b0;
        step();
        check("clr_pending_inexact", 32'(bus.out_valid & ~bus.exact), 32'd1);
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        check("cnt_clr_wins", 32'(inexact_cnt), 32'd0);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 400; n++) begin
            enable        = ($urandom_range(0, 9) != 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            cnt_clr       = ($urandom_range(0, 49) == 0);
            hist_sel      = 3'($urandom_range(0, 7));
            if (!(bus.in_valid && !last_inf)) begin
                bus.in_valid = ($urandom_range(0, 3) != 0);
                bus.rgb      = {rand_chan(), rand_chan(), rand_chan()};
            end
            step();
        end
        enable = 1'b1; bus.out_ready = 1'b1; cnt_clr = 1'b0; bus.in_valid = 1'b0;
        for (int n = 0; n < 10 && q.size() > 0; n++) step();
        check("final_drain", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule

// File: doc/rgb_to_colour.md
Name: rgb_to_colour

Overview:
Streaming encoder that maps a 24-bit RGB pixel {R[23:16],G[15:8],B[7:0]} onto the 3-bit colour code used by RGB_converter. It is the inverse direction of that converter: code 0..7 corresponds to 000000, 0000FF, 00FF00, 00FFFF, FF0000, FF00FF, FFFF00, FFFFFF.
- Two-stage valid/ready pipeline with backpressure and a global enable.
- Per-channel threshold quantisation.
- Flags pixels that are not exact palette values and keeps a saturating count of them.

Parameters:
THRESH, 128, channel value at or above this sets the channel bit (8-bit compare).
CNT_W, 16, width of the inexact-pixel counter and of the histogram bins.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous active-high reset
enable  input  1  high = pipeline runs; low = full freeze
in_valid  input  1  rgb holds a pixel
in_ready  output  1  block accepts pixel this cycle
rgb  input  24  pixel, R=[23:16] G=[15:8] B=[7:0]
out_valid  output  1  colour/exact hold a result
out_ready  input  1  downstream accepts result
colour  output  3  {R>=THRESH, G>=THRESH, B>=THRESH}
exact  output  1  every channel is 8'h00 or 8'hFF
cnt_clr  input  1  synchronous clear of counters
inexact_cnt  output  CNT_W  saturating count of inexact results delivered
hist_sel  input  3  histogram bin select (RGB_HIST_EN only)
hist_data  output  CNT_W  selected histogram bin (RGB_HIST_EN only)

Behaviour:
Reset (async, rst=1):
- s1_valid=0, out_valid=0, colour=0, exact=0, inexact_cnt=0, histogram bins=0.
- rst asserted mid-stream discards in-flight pixels immediately; no partial output is produced.

Stage 1:
- Input accept: in_fire = in_valid & in_ready.
- On in_fire, register c = {R>=THRESH, G>=THRESH, B>=THRESH} and e = exact test, and set s1_valid=1.

Stage 2 (output register):
- Output fire: out_fire = out_valid & out_ready.
- s1_move = enable & s1_valid & (~out_valid | out_ready).
- On s1_move: colour<=c, exact<=e, out_valid<=1.
- On out_fire without s1_move: out_valid<=0. colour/exact keep their last value.

Handshake:
- in_ready = enable & (~s1_valid | s1_move). It is combinational from out_ready and enable.
- s1_valid clears on s1_move unless in_fire occurs in the same cycle, in which case it stays set with the new data.
- Latency: pixel accepted at edge N appears at out_valid after edge N+1 (2 edges) when unstalled.
- Throughput: 1 pixel per cycle with out_ready=1.

Stall and freeze:
- With out_ready=0, at most 2 pixels are held and in_ready drops. No pixel is lost or duplicated.
- enable=0: in_ready=0 and no stage state changes. out_valid/colour hold, and out_fire is still honoured. Counters still update on out_fire.
- in_valid with in_ready=0: no effect. The source must hold rgb.

Counter:
- inexact_cnt += 1 on out_fire & ~exact.
- Saturates at 2^CNT_W-1, no wrap.
- cnt_clr=1 sets it to 0 on the next edge. cnt_clr wins over a simultaneous increment.

Optional Feature:
RGB_HIST_EN:
- Defined: 8 bins of CNT_W bits. Bin[colour] increments on every out_fire and saturates at max.
- cnt_clr zeroes all bins; clear wins over a simultaneous increment.
- hist_data is registered: it equals bin[hist_sel] as of the previous edge (1-cycle read latency) and resets to 0.
- Undefined: no bins are built and hist_data is tied to 0. hist_sel is ignored.

Test Plan:
- Palette sweep: enable=1, out_ready=1, rgb = 000000,0000FF,00FF00,00FFFF,FF0000,FF00FF,FFFF00,FFFFFF back-to-back -> colour 0..7 in order, 2 edges after each accept, exact=1 throughout, inexact_cnt=0.
- Threshold: rgb=7F8000 -> colour=2, exact=0. Then rgb=80807F -> colour=6, exact=0. inexact_cnt=2 after both out_fires.
- Backpressure: out_ready=0 while offering 4 pixels -> exactly 2 accepted, in_ready=0, colour holds the first. Then out_ready=1 -> all 4 delivered in order, no duplicates.
- Enable freeze: enable=0 for 5 cycles mid-stream with in_valid=1 -> in_ready=0, outputs stable. After enable=1, the stream resumes with no loss.
- Reset mid-operation: assert rst between clock edges with 2 pixels in flight -> out_valid=0, inexact_cnt=0 immediately. After release, the next pixel FF00FF gives colour=5.
- Counter saturation/clear (CNT_W=4): 17 inexact results -> inexact_cnt=15. cnt_clr coincident with an inexact out_fire -> 0. With RGB_HIST_EN, bin[5] reads 1 one cycle after hist_sel=5.
